// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU with single-cycle writeback.
// Optional EXU_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow go straight to writeback.
module exu_div #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_rem,
    input  logic             in_signed,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [4:0]       in_rd_addr,
    input  logic [TAG_W-1:0] in_instr_tag,
    output logic             busy,
    output logic             wb_valid,
    output logic [XLEN-1:0]  wb_data,
    output logic [4:0]       wb_rd_addr,
    output logic [TAG_W-1:0] wb_instr_tag
);

    localparam int unsigned     CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic             op_rem_q, op_rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;
    logic [4:0]       rd_q, rd_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;

    logic            accept;
    logic            early_out;
    logic            rs1_neg, rs2_neg;
    logic            in_div_zero, in_ovf;
    logic [XLEN-1:0] rs1_mag, rs2_mag;
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] q_fix, r_fix, fix_result;

    assign accept      = (state_q == StIdle) & in_valid & ~flush;
    assign rs1_neg     = in_signed & in_rs1_data[XLEN-1];
    assign rs2_neg     = in_signed & in_rs2_data[XLEN-1];
    assign rs1_mag     = rs1_neg ? -in_rs1_data : in_rs1_data;
    assign rs2_mag     = rs2_neg ? -in_rs2_data : in_rs2_data;
    assign in_div_zero = (in_rs2_data == '0);
    assign in_ovf      = in_signed & (in_rs1_data == MinNeg) & (in_rs2_data == '1);

    // One restoring step: shift {rem, quo} left and trial-subtract the divisor magnitude.
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};

`ifdef EXU_DIV_EARLY_OUT_EN
    logic [XLEN-1:0] early_result;

    assign early_out = in_div_zero | in_ovf;

    always_comb begin
        if (in_div_zero) begin
            early_result = in_rem ? in_rs1_data : '1;
        end else begin
            early_result = in_rem ? '0 : MinNeg;
        end
    end
`else
    assign early_out = 1'b0;
`endif

    always_comb begin
        q_fix = q_neg_q ? -quo_q : quo_q;
        r_fix = r_neg_q ? -rem_q : rem_q;
        if (div_zero_q) begin
            q_fix = '1;
            r_fix = rs1_q;
        end else if (ovf_q) begin
            q_fix = MinNeg;
            r_fix = '0;
        end
        fix_result = op_rem_q ? r_fix : q_fix;
    end

    // State register, including the datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            rs1_q      <= '0;
            op_rem_q   <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            rd_q       <= '0;
            tag_q      <= '0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            rs1_q      <= rs1_d;
            op_rem_q   <= op_rem_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            rd_q       <= rd_d;
            tag_q      <= tag_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_tag_q   <= wb_tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = early_out ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = flush ? StIdle : StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        rs1_d      = rs1_q;
        op_rem_d   = op_rem_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        rd_d       = rd_q;
        tag_d      = tag_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_tag_d   = wb_tag_q;
        if (accept) begin
            cnt_d      = CntLast;
            rem_d      = '0;
            quo_d      = rs1_mag;
            dvs_d      = rs2_mag;
            rs1_d      = in_rs1_data;
            op_rem_d   = in_rem;
            q_neg_d    = in_signed & (in_rs1_data[XLEN-1] ^ in_rs2_data[XLEN-1]);
            r_neg_d    = rs1_neg;
            div_zero_d = in_div_zero;
            ovf_d      = in_ovf;
            rd_d       = in_rd_addr;
            tag_d      = in_instr_tag;
`ifdef EXU_DIV_EARLY_OUT_EN
            if (early_out) begin
                wb_data_d = early_result;
                wb_rd_d   = in_rd_addr;
                wb_tag_d  = in_instr_tag;
            end
`endif
        end else if (state_q == StCalc) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CntW'(1);
            end
            if (!diff[XLEN]) begin
                rem_d = diff[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end else if ((state_q == StFix) && !flush) begin
            wb_data_d = fix_result;
            wb_rd_d   = rd_q;
            wb_tag_d  = tag_q;
        end
    end

    // A flush in the writeback cycle itself still kills the strobe.
    always_comb begin
        busy         = (state_q == StCalc) || (state_q == StFix);
        wb_valid     = (state_q == StDone) && !flush;
        wb_data      = wb_data_q;
        wb_rd_addr   = wb_rd_q;
        wb_instr_tag = wb_tag_q;
    end

endmodule
